// File: rtl/memory_fetch_pkg.sv
// Shared opcodes, error codes, FSM states and the halt word for the memory fetch unit.
package memory_fetch_pkg;

  localparam logic [1:0] OP_IFETCH = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RECOVER,
    ERR
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/memory_fetch_unit_if.sv
// CPU-side request/response and MAIN_MEMORY bus signals of the memory fetch unit.
interface memory_fetch_unit_if #(
  parameter int DATAWIDTH_BUS = 32
);
  logic                     MEMORY_FETCH_REQ_In;
  logic [1:0]               MEMORY_FETCH_OP_In;
  logic [DATAWIDTH_BUS-1:0] MEMORY_FETCH_ADDRESS_InBUS;
  logic [DATAWIDTH_BUS-1:0] MEMORY_FETCH_WRDATA_InBUS;
  logic                     MEMORY_FETCH_BUSY_Out;
  logic                     MEMORY_FETCH_DONE_Out;
  logic [1:0]               MEMORY_FETCH_ERROR_Out;
  logic [DATAWIDTH_BUS-1:0] MEMORY_FETCH_IR_OutBUS;
  logic [DATAWIDTH_BUS-1:0] MEMORY_FETCH_LDDATA_OutBUS;
  logic                     MEMORY_FETCH_HALT_Out;
  logic [DATAWIDTH_BUS-1:0] MEMORY_FETCH_MEM_ADDRESS_OutBUS;
  logic [DATAWIDTH_BUS-1:0] MEMORY_FETCH_MEM_data_OutBUS;
  logic                     MEMORY_FETCH_MEM_RD_Out;
  logic                     MEMORY_FETCH_MEM_WR_Out;
  logic [DATAWIDTH_BUS-1:0] MEMORY_FETCH_MEM_data_InBUS;
  logic                     MEMORY_FETCH_MEM_ACK_In;

  // The fetch unit's view: it serves the CPU and masters MAIN_MEMORY.
  modport master (
    input  MEMORY_FETCH_REQ_In, MEMORY_FETCH_OP_In, MEMORY_FETCH_ADDRESS_InBUS,
           MEMORY_FETCH_WRDATA_InBUS, MEMORY_FETCH_MEM_data_InBUS, MEMORY_FETCH_MEM_ACK_In,
    output MEMORY_FETCH_BUSY_Out, MEMORY_FETCH_DONE_Out, MEMORY_FETCH_ERROR_Out,
           MEMORY_FETCH_IR_OutBUS, MEMORY_FETCH_LDDATA_OutBUS, MEMORY_FETCH_HALT_Out,
           MEMORY_FETCH_MEM_ADDRESS_OutBUS, MEMORY_FETCH_MEM_data_OutBUS,
           MEMORY_FETCH_MEM_RD_Out, MEMORY_FETCH_MEM_WR_Out
  );

  modport slave (
    output MEMORY_FETCH_REQ_In, MEMORY_FETCH_OP_In, MEMORY_FETCH_ADDRESS_InBUS,
           MEMORY_FETCH_WRDATA_InBUS, MEMORY_FETCH_MEM_data_InBUS, MEMORY_FETCH_MEM_ACK_In,
    input  MEMORY_FETCH_BUSY_Out, MEMORY_FETCH_DONE_Out, MEMORY_FETCH_ERROR_Out,
           MEMORY_FETCH_IR_OutBUS, MEMORY_FETCH_LDDATA_OutBUS, MEMORY_FETCH_HALT_Out,
           MEMORY_FETCH_MEM_ADDRESS_OutBUS, MEMORY_FETCH_MEM_data_OutBUS,
           MEMORY_FETCH_MEM_RD_Out, MEMORY_FETCH_MEM_WR_Out
  );
endinterface

// File: rtl/memory_fetch_wait_counter.sv
// Saturating ACCESS-cycle counter; reached flags the cycle whose increment hits the limit.
module memory_fetch_wait_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             reached
);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= sat_inc(count);
    end
  end

  // Compare the post-increment value so the transition happens on the limit-th cycle.
  assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
  assign reached   = enable && (count_inc >= {1'b0, limit});

endmodule

// File: rtl/memory_fetch_unit.sv
// Bus master sequencing MAIN_MEMORY reads/writes for ifetch, load and store requests.
module memory_fetch_unit
  import memory_fetch_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 32,
  parameter int USE_ACK       = 1,
  parameter int FIXED_WAIT    = 2,
  parameter int TIMEOUT       = 16
) (
  input logic                 MEMORY_FETCH_CLOCK_50,
  input logic                 MEMORY_FETCH_RESET_InHigh,
  memory_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(max_int(TIMEOUT, FIXED_WAIT) + 1);
  localparam int LIMIT = (USE_ACK != 0) ? TIMEOUT : FIXED_WAIT;

  state_t                   state, state_nxt;
  logic [1:0]               op_q, err_q, err_nxt;
  logic [DATAWIDTH_BUS-1:0] ir_q, ld_q, maddr_q, mdata_q;
  logic                     halt_q, wait_reached, capture;

  memory_fetch_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait (
    .clk     (MEMORY_FETCH_CLOCK_50),
    .rst     (MEMORY_FETCH_RESET_InHigh),
    .clear   (state == SETUP),
    .enable  (state == ACCESS),
    .limit   (CNT_W'(LIMIT)),
    .reached (wait_reached)
  );

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MEMORY_FETCH_REQ_In) begin
          if (bus.MEMORY_FETCH_OP_In == 2'b11 || halt_q) begin
            state_nxt = ERR;
            err_nxt   = ERR_ILLEGAL;
          end else if (bus.MEMORY_FETCH_ADDRESS_InBUS[1:0] != 2'b00) begin
            state_nxt = ERR;
            err_nxt   = ERR_MISALIGN;
          end else begin
            state_nxt = SETUP;
          end
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        // ACK wins over a simultaneous timeout.
        if (USE_ACK != 0) begin
          if (bus.MEMORY_FETCH_MEM_ACK_In) begin
            state_nxt = RECOVER;
            capture   = 1'b1;
          end else if (wait_reached) begin
            state_nxt = ERR;
            err_nxt   = ERR_TIMEOUT;
          end
        end else if (wait_reached) begin
          state_nxt = RECOVER;
          capture   = 1'b1;
        end
      end
      RECOVER: state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge MEMORY_FETCH_CLOCK_50) begin
    if (MEMORY_FETCH_RESET_InHigh) begin
      state   <= IDLE;
      op_q    <= OP_IFETCH;
      err_q   <= ERR_OK;
      ir_q    <= '0;
      ld_q    <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (state == IDLE && bus.MEMORY_FETCH_REQ_In) begin
        op_q <= bus.MEMORY_FETCH_OP_In;
      end
      if (state == IDLE && state_nxt == SETUP) begin
        maddr_q <= bus.MEMORY_FETCH_ADDRESS_InBUS;
        mdata_q <= bus.MEMORY_FETCH_WRDATA_InBUS;
      end
      if (capture && op_q == OP_IFETCH) begin
        ir_q <= bus.MEMORY_FETCH_MEM_data_InBUS;
      end
      if (capture && op_q == OP_LOAD) begin
        ld_q <= bus.MEMORY_FETCH_MEM_data_InBUS;
      end
      // IR only changes on an ifetch capture, so in RECOVER it holds this fetch's word.
      if (state == RECOVER && op_q == OP_IFETCH && ir_q == DATAWIDTH_BUS'(HALT_WORD)) begin
        halt_q <= 1'b1;
      end
    end
  end

  assign bus.MEMORY_FETCH_BUSY_Out           = (state != IDLE);
  assign bus.MEMORY_FETCH_DONE_Out           = (state == RECOVER) || (state == ERR);
  assign bus.MEMORY_FETCH_ERROR_Out          = (state == ERR) ? err_q : ERR_OK;
  assign bus.MEMORY_FETCH_IR_OutBUS          = ir_q;
  assign bus.MEMORY_FETCH_LDDATA_OutBUS      = ld_q;
  assign bus.MEMORY_FETCH_HALT_Out           = halt_q;
  assign bus.MEMORY_FETCH_MEM_ADDRESS_OutBUS = maddr_q;
  assign bus.MEMORY_FETCH_MEM_data_OutBUS    = mdata_q;
  assign bus.MEMORY_FETCH_MEM_RD_Out         = !(state == ACCESS && op_q != OP_STORE);
  assign bus.MEMORY_FETCH_MEM_WR_Out         = !(state == ACCESS && op_q == OP_STORE);

endmodule
